postbox_spi_master: RTL

//  SPI mode-0 master for the 16-bit framed link used by the post_box FPGA bridge, i.e. the MCU's side of that link.

---
 rtl/postbox_spi_master_if.sv | 31 +++
 rtl/postbox_spi_master.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/postbox_spi_master_if.sv
// Host-side byte handshake of postbox_spi_master.
// master: the local host; slave: the SPI framing engine.
interface postbox_spi_master_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_done;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;

    modport master (
        output tx_data,
        output tx_valid,
        output rx_ready,
        input  tx_done,
        input  rx_data,
        input  rx_valid,
        input  busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  rx_ready,
        output tx_done,
        output rx_data,
        output rx_valid,
        output busy
    );
endinterface

// File: rtl/postbox_spi_master.sv
// SPI mode-0 master for the post_box 16-bit framed link.
// Each frame swaps handshake flags and optionally one byte each way.
module postbox_spi_master #(
    parameter int HALF_PERIOD   = 8,
    parameter int CS_SETUP      = 8,
    parameter int CS_GAP        = 8,
    parameter int POLL_INTERVAL = 4800
) (
    input  logic fpga_clock_48mhz,
    input  logic reset,
    output logic spi_cs,
    output logic spi_sck,
    output logic spi_mosi,
    input  logic spi_miso,
    postbox_spi_master_if.slave host
);

    localparam int MAX_A = (HALF_PERIOD > CS_SETUP) ? HALF_PERIOD : CS_SETUP;
    localparam int MAX_T = (MAX_A > CS_GAP) ? MAX_A : CS_GAP;
    localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int PW    = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [3:0]  edge_cnt;
    logic [3:0]  edge_next;
    logic [PW-1:0] poll_cnt;
    logic [PW-1:0] poll_next;
    logic [15:0] frame;
    logic [15:0] frame_next;
    logic        has_byte;
    logic        has_byte_next;
    logic        has_space;
    logic        has_space_next;
    logic [7:0]  shifter;
    logic [7:0]  shifter_next;
    logic        cs;
    logic        cs_next;
    logic        sck;
    logic        sck_next;
    logic        mosi;
    logic        mosi_next;
    logic        tx_done;
    logic        tx_done_next;
    logic        rx_valid;
    logic        rx_valid_next;
    logic [7:0]  rx_data;
    logic [7:0]  rx_data_next;
    logic        sample;
    logic        poll_due;
    logic        miso_meta;
    logic        miso_s;

    assign poll_due = (POLL_INTERVAL != 0)
                   && (poll_cnt == PW'(POLL_INTERVAL - 1));

    // Two-flop synchroniser for the asynchronous MISO pin.
    always_ff @(posedge fpga_clock_48mhz) begin
        if (reset) begin
            miso_meta <= 1'b0;
            miso_s    <= 1'b0;
        end else begin
            miso_meta <= spi_miso;
            miso_s    <= miso_meta;
        end
    end

    // Frame sequencer: phase timing, MOSI bit selection and outcome.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt + 1'b1;
        edge_next      = edge_cnt;
        poll_next      = poll_cnt;
        frame_next     = frame;
        has_byte_next  = has_byte;
        has_space_next = has_space;
        shifter_next   = shifter;
        cs_next        = cs;
        sck_next       = sck;
        mosi_next      = mosi;
        tx_done_next   = 1'b0;
        rx_valid_next  = 1'b0;
        rx_data_next   = rx_data;
        sample         = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_next = '0;
                if (host.tx_valid || poll_due) begin
                    state_next = SETUP;
                    poll_next  = '0;
                    edge_next  = 4'd0;
                    cs_next    = 1'b0;
                    mosi_next  = host.tx_valid;
                    frame_next = {host.tx_valid, host.rx_ready, 6'b000000,
                                  host.tx_valid ? host.tx_data : 8'h00};
                end else if (POLL_INTERVAL != 0) begin
                    poll_next = poll_cnt + 1'b1;
                end
            end
            SETUP: begin
                if (cnt == CW'(CS_SETUP - 1)) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                    sck_next   = 1'b1;
                    sample     = 1'b1;
                end
            end
            HIGH: begin
                if (cnt == CW'(HALF_PERIOD - 1)) begin
                    cnt_next = '0;
                    sck_next = 1'b0;
                    if (edge_cnt == 4'd15) begin
                        state_next = HOLD;
                        mosi_next  = 1'b0;
                    end else begin
                        state_next = LOW;
                        mosi_next  = frame[4'd14 - edge_cnt];
                    end
                end
            end
            LOW: begin
                if (cnt == CW'(HALF_PERIOD - 1)) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                    sck_next   = 1'b1;
                    edge_next  = edge_cnt + 1'b1;
                    sample     = 1'b1;
                end
            end
            HOLD: begin
                if (cnt == CW'(HALF_PERIOD - 1)) begin
                    state_next   = GAP;
                    cnt_next     = '0;
                    cs_next      = 1'b1;
                    edge_next    = 4'd0;
                    tx_done_next = frame[15] & has_space;
                    if (frame[14] && has_byte) begin
                        rx_valid_next = 1'b1;
                        rx_data_next  = shifter;
                    end
                end
            end
            GAP: begin
                if (cnt == CW'(CS_GAP - 1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    poll_next  = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (sample) begin
            unique case (1'b1)
                (edge_next == 4'd0): has_byte_next  = miso_s;
                (edge_next == 4'd1): has_space_next = miso_s;
                edge_next[3]:        shifter_next   = {shifter[6:0], miso_s};
                default: ;
            endcase
        end
    end

    // State and output registers; reset forces the pins idle at once.
    always_ff @(posedge fpga_clock_48mhz) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            edge_cnt  <= 4'd0;
            poll_cnt  <= '0;
            frame     <= 16'h0000;
            has_byte  <= 1'b0;
            has_space <= 1'b0;
            shifter   <= 8'h00;
            cs        <= 1'b1;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            tx_done   <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= 8'h00;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            edge_cnt  <= edge_next;
            poll_cnt  <= poll_next;
            frame     <= frame_next;
            has_byte  <= has_byte_next;
            has_space <= has_space_next;
            shifter   <= shifter_next;
            cs        <= cs_next;
            sck       <= sck_next;
            mosi      <= mosi_next;
            tx_done   <= tx_done_next;
            rx_valid  <= rx_valid_next;
            rx_data   <= rx_data_next;
        end
    end

    assign spi_cs        = cs;
    assign spi_sck       = sck;
    assign spi_mosi      = mosi;
    assign host.tx_done  = tx_done;
    assign host.rx_valid = rx_valid;
    assign host.rx_data  = rx_data;
    assign host.busy     = (state != IDLE);

endmodule
